// File: rtl/text_buf_ctrl.sv
// text_buf_ctrl: keyboard-driven text buffer controller for a ROWS x COLS
// character RAM. Clears the screen and prints a banner after reset, then
// handles printable keys, cursor left/right, backspace and enter. A new
// command prompt is printed on enter. When the text reaches the bottom
// row, the screen is scrolled up by one row.
//
// Ports
//   clk, clrn               clock, synchronous active-high reset
//   key_valid, key_special  key event in; key_special selects the kind of key
//   key_ascii               character code for printable keys
//   key_ready               high while the controller can accept an event
//   wr_en/wr_addr/wr_data   character RAM write port (one write per cycle)
//   rd_addr/rd_data         character RAM read port (data one cycle later)
//   cur_x/cur_y             cursor column/row
//   end_x/end_y             end-of-text column/row
//   busy                    high whenever not idle
//   state_dbg               current FSM state, for observation only
//
// Handshake: a key event is accepted on a rising edge where key_valid and
// key_ready are both high. key_ready is high only in IDLE. An event
// presented while busy is dropped, not queued.
module text_buf_ctrl #(
    parameter int ROWS       = 30,
    parameter int COLS       = 70,
    parameter int PROMPT_LEN = 10
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        key_valid,
    input  logic [3:0]  key_special,
    input  logic [7:0]  key_ascii,
    output logic        key_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [11:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic [6:0]  end_x,
    output logic [4:0]  end_y,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        INIT_CLR = 3'd0,
        INIT_MSG = 3'd1,
        IDLE     = 3'd2,
        PROMPT   = 3'd3,
        SCROLL   = 3'd4,
        CLR_ROW  = 3'd5
    } state_t;

    localparam logic [3:0]  K_CHAR     = 4'd0;
    localparam logic [3:0]  K_LEFT     = 4'd1;
    localparam logic [3:0]  K_RIGHT    = 4'd4;
    localparam logic [3:0]  K_ENTER    = 4'd5;
    localparam logic [3:0]  K_BKSP     = 4'd6;

    localparam logic [6:0]  COL_LAST   = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);
    localparam logic [6:0]  PROMPT_COL = 7'(PROMPT_LEN);
    localparam logic [11:0] COLS12     = 12'(COLS);
    localparam logic [11:0] CELLS      = 12'(ROWS * COLS);
    localparam logic [11:0] SCROLL_N   = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] MSG_LEN    = 12'd8;
    localparam logic [11:0] PROMPT_END = 12'(PROMPT_LEN - 1);
    localparam logic [4:0]  HOME_ROW   = 5'd2;

    function automatic logic [7:0] prompt_char(input logic [3:0] i);
        case (i)
            4'd0:    prompt_char = 8'h4E;
            4'd1:    prompt_char = 8'h41;
            4'd2:    prompt_char = 8'h4E;
            4'd3:    prompt_char = 8'h40;
            4'd4:    prompt_char = 8'h4E;
            4'd5:    prompt_char = 8'h41;
            4'd6:    prompt_char = 8'h4E;
            4'd7:    prompt_char = 8'h3A;
            4'd8:    prompt_char = 8'h7E;
            4'd9:    prompt_char = 8'h24;
            default: prompt_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] welcome_char(input logic [2:0] i);
        case (i)
            3'd0:    welcome_char = 8'h57;
            3'd1:    welcome_char = 8'h65;
            3'd2:    welcome_char = 8'h6C;
            3'd3:    welcome_char = 8'h63;
            3'd4:    welcome_char = 8'h6F;
            3'd5:    welcome_char = 8'h6D;
            3'd6:    welcome_char = 8'h65;
            default: welcome_char = 8'h21;
        endcase
    endfunction

    function automatic logic [11:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        cell_addr = {7'd0, y} * COLS12 + {5'd0, x};
    endfunction

    state_t            state, state_n;
    logic [11:0]       cnt, cnt_n;
    logic [6:0]        cur_x_n, end_x_n;
    logic [4:0]        cur_y_n, end_y_n;
    logic [ROWS-1:0]   line_flag, line_flag_n;
    logic [4:0]        prow, prow_n;      // row the prompt is written to
    logic              pmode, pmode_n;    // scroll was started by enter
    logic              wr_en_c;
    logic [11:0]       wr_addr_c, rd_addr_c;
    logic [7:0]        wr_data_c;

    // Cursor neighbourhood, evaluated only in IDLE.
    logic [6:0]  prev_x, next_x;
    logic [4:0]  prev_y, next_y, tgt_row;
    logic        at_prompt_edge, at_home, at_origin, at_last;
    logic        cur_eq_end, cur_before_end, accept;
    logic [11:0] msg_idx;

    always_ff @(posedge clk) begin
        if (clrn) begin
            state     <= INIT_CLR;
            cnt       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            end_x     <= '0;
            end_y     <= '0;
            line_flag <= '0;
            prow      <= '0;
            pmode     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cur_x     <= cur_x_n;
            cur_y     <= cur_y_n;
            end_x     <= end_x_n;
            end_y     <= end_y_n;
            line_flag <= line_flag_n;
            prow      <= prow_n;
            pmode     <= pmode_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cur_x_n     = cur_x;
        cur_y_n     = cur_y;
        end_x_n     = end_x;
        end_y_n     = end_y;
        line_flag_n = line_flag;
        prow_n      = prow;
        pmode_n     = pmode;
        wr_en_c     = 1'b0;
        wr_addr_c   = '0;
        wr_data_c   = '0;
        rd_addr_c   = '0;
        msg_idx     = cnt - MSG_LEN;

        prev_x  = (cur_x == 7'd0) ? COL_LAST : cur_x - 7'd1;
        prev_y  = (cur_x == 7'd0) ? cur_y - 5'd1 : cur_y;
        next_x  = (cur_x == COL_LAST) ? 7'd0 : cur_x + 7'd1;
        next_y  = (cur_x == COL_LAST) ? cur_y + 5'd1 : cur_y;
        tgt_row = end_y + 5'd1;

        // The prompt and the banner rows are protected from cursor moves.
        at_prompt_edge = line_flag[cur_y] && (cur_x == PROMPT_COL);
        at_home        = (cur_x == 7'd0) && (cur_y == HOME_ROW);
        at_origin      = (cur_x == 7'd0) && (cur_y == 5'd0);
        at_last        = (cur_x == COL_LAST) && (cur_y == ROW_LAST);
        cur_eq_end     = (cur_x == end_x) && (cur_y == end_y);
        cur_before_end = (cur_y < end_y) || ((cur_y == end_y) && (cur_x < end_x));
        accept         = key_valid && (state == IDLE);

        case (state)
            INIT_CLR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = cnt;
                if (cnt == CELLS - 12'd1) begin
                    state_n = INIT_MSG;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            INIT_MSG: begin
                // Banner at the top-left, then the first prompt on row 2.
                wr_en_c = 1'b1;
                if (cnt < MSG_LEN) begin
                    wr_addr_c = cnt;
                    wr_data_c = welcome_char(cnt[2:0]);
                end else begin
                    wr_addr_c = cell_addr(msg_idx[6:0], HOME_ROW);
                    wr_data_c = prompt_char(msg_idx[3:0]);
                end
                if (cnt == MSG_LEN + PROMPT_END) begin
                    line_flag_n           = '0;
                    line_flag_n[HOME_ROW] = 1'b1;
                    cur_x_n = PROMPT_COL;
                    cur_y_n = HOME_ROW;
                    end_x_n = PROMPT_COL;
                    end_y_n = HOME_ROW;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            IDLE: begin
                if (accept) begin
                    case (key_special)
                        K_CHAR: begin
                            wr_en_c   = 1'b1;
                            wr_addr_c = cell_addr(cur_x, cur_y);
                            wr_data_c = key_ascii;
                            if (at_last) begin
                                // Rows move up; the new bottom row carries no prompt.
                                line_flag_n = {1'b0, line_flag[ROWS-1:1]};
                                pmode_n     = 1'b0;
                                cnt_n       = '0;
                                state_n     = SCROLL;
                            end else begin
                                cur_x_n = next_x;
                                cur_y_n = next_y;
                                if (cur_eq_end) begin
                                    end_x_n = next_x;
                                    end_y_n = next_y;
                                end
                            end
                        end
                        K_LEFT: begin
                            if (!at_prompt_edge && !at_home && !at_origin) begin
                                cur_x_n = prev_x;
                                cur_y_n = prev_y;
                            end
                        end
                        K_RIGHT: begin
                            if (cur_before_end) begin
                                cur_x_n = next_x;
                                cur_y_n = next_y;
                            end
                        end
                        K_ENTER: begin
                            cnt_n = '0;
                            if (end_y < ROW_LAST) begin
                                line_flag_n[tgt_row] = 1'b1;
                                prow_n  = tgt_row;
                                state_n = PROMPT;
                            end else begin
                                line_flag_n = {1'b1, line_flag[ROWS-1:1]};
                                pmode_n     = 1'b1;
                                state_n     = SCROLL;
                            end
                        end
                        K_BKSP: begin
                            if (cur_eq_end && !at_home && !at_prompt_edge && !at_origin) begin
                                wr_en_c   = 1'b1;
                                wr_addr_c = cell_addr(prev_x, prev_y);
                                wr_data_c = 8'h00;
                                cur_x_n   = prev_x;
                                cur_y_n   = prev_y;
                                end_x_n   = prev_x;
                                end_y_n   = prev_y;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            PROMPT: begin
                wr_en_c   = 1'b1;
                wr_addr_c = cell_addr(cnt[6:0], prow);
                wr_data_c = prompt_char(cnt[3:0]);
                if (cnt == PROMPT_END) begin
                    cur_x_n = PROMPT_COL;
                    cur_y_n = prow;
                    end_x_n = PROMPT_COL;
                    end_y_n = prow;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            SCROLL: begin
                // Read one row below at cnt; the data arrives next cycle
                // and is written one row up at cnt-1.
                if (cnt < SCROLL_N) begin
                    rd_addr_c = cnt + COLS12;
                end
                if (cnt != 12'd0) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = cnt - 12'd1;
                    wr_data_c = rd_data;
                end
                if (cnt == SCROLL_N) begin
                    state_n = CLR_ROW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            CLR_ROW: begin
                wr_en_c   = 1'b1;
                wr_addr_c = SCROLL_N + cnt;
                if (cnt == COLS12 - 12'd1) begin
                    cnt_n = '0;
                    if (pmode) begin
                        prow_n  = ROW_LAST;
                        state_n = PROMPT;
                    end else begin
                        cur_x_n = 7'd0;
                        cur_y_n = ROW_LAST;
                        end_x_n = 7'd0;
                        end_y_n = ROW_LAST;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            default: begin
                state_n = INIT_CLR;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are forced inactive while reset is held, so a reset landing
    // mid-sequence cuts the write stream off in that same cycle.
    assign wr_en     = wr_en_c && !clrn;
    assign wr_addr   = wr_addr_c;
    assign wr_data   = wr_data_c;
    assign rd_addr   = rd_addr_c;
    assign key_ready = (state == IDLE) && !clrn;
    assign busy      = (state != IDLE) || clrn;
    assign state_dbg = state;

endmodule
